// File: rtl/temporizador_ctrl.sv
// -----------------------------------------------------------------------------
// temporizador_ctrl
//
// Programmable interval timer. A prescaler divides the clock into count ticks.
// The count runs modulo N+1, either upward (0..N) or downward (N..0). In
// one-shot mode the block stops after the terminal tick. In periodic mode it
// reloads and keeps running. A ready/start handshake launches each operation,
// and pause/abort give the requester control while the timer runs.
//
// Parameters
//   PRESCALE   clock cycles per count tick (>= 1)
//   MAX_COUNT  largest programmable terminal value
//   WIDTH      derived width of the count and load value
//
// Ports
//   iCLOCK      clock, rising edge
//   iRESET_n    asynchronous active-low reset
//   iSTART      start request, honoured only while oREADY=1
//   iLOAD_VAL   terminal value N (clamped to MAX_COUNT)
//   iUP_DOWN    1 = count up 0->N, 0 = count down N->0 (latched at start)
//   iPERIODIC   1 = reload and continue, 0 = one-shot (latched at start)
//   iPAUSE      freezes the prescaler and the count while running
//   iABORT      cancels the operation and returns the block to idle
//   oREADY      idle, ready for a start
//   oBUSY       operation in progress (run or done)
//   oCOUNT      current count
//   oTICK       one-cycle pulse after each count advance
//   oTC         one-cycle pulse after each terminal tick
//   oDONE       one-cycle pulse on one-shot completion
// -----------------------------------------------------------------------------
module temporizador_ctrl #(
  parameter int PRESCALE  = 4,
  parameter int MAX_COUNT = 255,
  localparam int WIDTH    = $clog2(MAX_COUNT + 1)
) (
  input  logic             iCLOCK,
  input  logic             iRESET_n,
  input  logic             iSTART,
  input  logic [WIDTH-1:0] iLOAD_VAL,
  input  logic             iUP_DOWN,
  input  logic             iPERIODIC,
  input  logic             iPAUSE,
  input  logic             iABORT,
  output logic             oREADY,
  output logic             oBUSY,
  output logic [WIDTH-1:0] oCOUNT,
  output logic             oTICK,
  output logic             oTC,
  output logic             oDONE
);

  // A one-cycle prescaler still needs a one-bit register.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MAX_COUNT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic             up_q, up_d;
  logic             per_q, per_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] load_clamped;
  logic             terminal;

  assign load_clamped = (iLOAD_VAL > MAX_VAL) ? MAX_VAL : iLOAD_VAL;

  // Terminal count depends on the direction that was latched at start.
  assign terminal = up_q ? (count_q == n_q) : (count_q == '0);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    n_d     = n_q;
    up_d    = up_q;
    per_d   = per_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // If start and abort arrive together, abort wins and nothing launches.
        if (iSTART && !iABORT) begin
          n_d     = load_clamped;
          up_d    = iUP_DOWN;
          per_d   = iPERIODIC;
          count_d = iUP_DOWN ? '0 : load_clamped;
          presc_d = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (iABORT) begin
          // Count holds its last value; no tick, tc or done is produced.
          state_d = S_IDLE;
        end else if (!iPAUSE) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (terminal) begin
              tc_d = 1'b1;
              if (per_q) begin
                count_d = up_q ? '0 : n_q;
              end else begin
                // One-shot: leave the count on its terminal value.
                state_d = S_DONE;
              end
            end else begin
              count_d = up_q ? (count_q + 1'b1) : (count_q - 1'b1);
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLOCK or negedge iRESET_n) begin
    if (!iRESET_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      count_q <= '0;
      n_q     <= '0;
      up_q    <= 1'b0;
      per_q   <= 1'b0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      n_q     <= n_d;
      up_q    <= up_d;
      per_q   <= per_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
    end
  end

  assign oREADY = (state_q == S_IDLE);
  assign oBUSY  = (state_q == S_RUN) || (state_q == S_DONE);
  assign oDONE  = (state_q == S_DONE);
  assign oCOUNT = count_q;
  assign oTICK  = tick_q;
  assign oTC    = tc_q;

endmodule

// File: tb/tb_temporizador_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for temporizador_ctrl.
// MAX_COUNT is set to 200 so that an 8-bit load value can exceed it and the
// clamp can be observed. A reference model follows the timer from elapsed
// active cycles: tick index k = elapsed / PRESCALE and count = k mod (N+1).
// Directed scenarios come first, then a randomized run.
// -----------------------------------------------------------------------------
module tb_temporizador_ctrl;

  localparam int P    = 4;
  localparam int MAXC = 200;
  localparam int W    = 8;

  logic         iCLOCK = 1'b0;
  logic         iRESET_n;
  logic         iSTART;
  logic [W-1:0] iLOAD_VAL;
  logic         iUP_DOWN;
  logic         iPERIODIC;
  logic         iPAUSE;
  logic         iABORT;
  logic         oREADY;
  logic         oBUSY;
  logic [W-1:0] oCOUNT;
  logic         oTICK;
  logic         oTC;
  logic         oDONE;

  temporizador_ctrl #(.PRESCALE(P), .MAX_COUNT(MAXC)) dut (
    .iCLOCK   (iCLOCK),
    .iRESET_n (iRESET_n),
    .iSTART   (iSTART),
    .iLOAD_VAL(iLOAD_VAL),
    .iUP_DOWN (iUP_DOWN),
    .iPERIODIC(iPERIODIC),
    .iPAUSE   (iPAUSE),
    .iABORT   (iABORT),
    .oREADY   (oREADY),
    .oBUSY    (oBUSY),
    .oCOUNT   (oCOUNT),
    .oTICK    (oTICK),
    .oTC      (oTC),
    .oDONE    (oDONE)
  );

  always #5 iCLOCK = ~iCLOCK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = completion cycle.
  int m_mode, m_n, m_elapsed, m_count;
  bit m_up, m_per, m_tick, m_tc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_elapsed = 0; m_count = 0;
    m_up = 0; m_per = 0; m_tick = 0; m_tc = 0;
  endtask

  task automatic model_step(input bit st, input bit ab, input bit pa, input int ld,
                            input bit ud, input bit pe);
    int k;
    m_tick = 0;
    m_tc   = 0;
    case (m_mode)
      0: if (st && !ab) begin
        m_n       = (ld > MAXC) ? MAXC : ld;
        m_up      = ud;
        m_per     = pe;
        m_elapsed = 0;
        m_count   = ud ? 0 : m_n;
        m_mode    = 1;
      end
      1: if (ab) begin
        m_mode = 0;
      end else if (!pa) begin
        m_elapsed++;
        if (m_elapsed % P == 0) begin
          k      = m_elapsed / P;
          m_tick = 1;
          if (k % (m_n + 1) == 0) begin
            m_tc = 1;
            if (!m_per) m_mode = 2;
          end
          if (!m_per && k == m_n + 1) m_count = m_up ? m_n : 0;
          else m_count = m_up ? (k % (m_n + 1)) : (m_n - k % (m_n + 1));
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic compare_all();
    check_eq("count", 32'(oCOUNT), 32'(m_count));
    check_eq("tick",  32'(oTICK),  32'(m_tick));
    check_eq("tc",    32'(oTC),    32'(m_tc));
    check_eq("done",  32'(oDONE),  32'(m_mode == 2));
    check_eq("ready", 32'(oREADY), 32'(m_mode == 0));
    check_eq("busy",  32'(oBUSY),  32'(m_mode != 0));
  endtask

  // One clock cycle: drive inputs at the falling edge, model the rising edge,
  // then compare in the middle of the following cycle.
  task automatic cycle(input bit st, input bit ab, input bit pa, input int ld,
                       input bit ud, input bit pe);
    iSTART = st; iABORT = ab; iPAUSE = pa; iLOAD_VAL = W'(ld);
    iUP_DOWN = ud; iPERIODIC = pe;
    @(posedge iCLOCK);
    cyc++;
    model_step(st, ab, pa, int'(iLOAD_VAL), ud, pe);
    @(negedge iCLOCK);
    compare_all();
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int done_at, last_tc, n_tc, n_done;
    int ticks[$];

    iRESET_n = 1'b0; iSTART = 0; iABORT = 0; iPAUSE = 0;
    iLOAD_VAL = '0; iUP_DOWN = 0; iPERIODIC = 0;
    model_reset();
    repeat (2) @(negedge iCLOCK);
    compare_all();
    iRESET_n = 1'b1;

    // One-shot up, N=3.
    cyc = 0; done_at = -1; ticks.delete();
    cycle(1, 0, 0, 3, 1, 0);
    for (int i = 0; i < 40 && done_at < 0; i++) begin
      idle_cycle();
      if (oTICK) ticks.push_back(cyc);
      if (oDONE) begin
        done_at = cyc;
        check_eq("oneshot_tc_with_done", 32'(oTC), 1);
        check_eq("oneshot_final_count", 32'(oCOUNT), 3);
      end
    end
    check_eq("oneshot_done_cycle", done_at, 17);
    check_eq("oneshot_tick_count", ticks.size(), 4);
    if (ticks.size() >= 3) begin
      check_eq("oneshot_tick1", ticks[0], 5);
      check_eq("oneshot_tick2", ticks[1], 9);
      check_eq("oneshot_tick3", ticks[2], 13);
    end
    idle_cycle();
    check_eq("oneshot_ready_cycle18", 32'(oREADY), 1);
    $display("one-shot up N=3: done at cycle %0d", done_at);

    // One-shot up, N=3, paused for 5 cycles mid-period.
    cyc = 0; done_at = -1;
    cycle(1, 0, 0, 3, 1, 0);
    while (cyc < 6) idle_cycle();
    repeat (5) cycle(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 40 && done_at < 0; i++) begin
      idle_cycle();
      if (oDONE) done_at = cyc;
    end
    check_eq("pause_done_cycle", done_at, 22);
    idle_cycle();
    $display("one-shot paused 5: done at cycle %0d", done_at);

    // Abort during cycle 8 of a one-shot, then start together with abort.
    cyc = 0;
    cycle(1, 0, 0, 3, 1, 0);
    while (cyc < 8) idle_cycle();
    cycle(0, 1, 0, 0, 0, 0);
    check_eq("abort_ready", 32'(oREADY), 1);
    check_eq("abort_count_held", 32'(oCOUNT), 1);
    check_eq("abort_no_done", 32'(oDONE), 0);
    check_eq("abort_no_tc", 32'(oTC), 0);
    cycle(1, 1, 0, 3, 1, 0);
    check_eq("start_abort_no_start", 32'(oREADY), 1);
    idle_cycle();
    $display("abort at cycle 8: count %0d ready %0d", oCOUNT, oREADY);

    // Periodic down, N=2: terminal every 12 cycles, never done.
    cyc = 0; last_tc = -1; n_tc = 0; n_done = 0;
    cycle(1, 0, 0, 2, 0, 1);
    for (int i = 0; i < 60; i++) begin
      idle_cycle();
      if (oDONE) n_done++;
      if (oTC) begin
        if (last_tc < 0) check_eq("periodic_first_tc", cyc, 13);
        else check_eq("periodic_tc_interval", cyc - last_tc, 12);
        last_tc = cyc;
        n_tc++;
      end
    end
    check_eq("periodic_tc_seen", 32'(n_tc >= 4), 1);
    check_eq("periodic_no_done", n_done, 0);
    // Start while running is ignored (the model keeps the old operation).
    cycle(1, 0, 0, 5, 1, 0);
    repeat (3) idle_cycle();
    // Asynchronous reset in the middle of the run.
    #1 iRESET_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_count", 32'(oCOUNT), 0);
    check_eq("async_rst_ready", 32'(oREADY), 1);
    check_eq("async_rst_busy",  32'(oBUSY), 0);
    check_eq("async_rst_tc",    32'(oTC), 0);
    check_eq("async_rst_done",  32'(oDONE), 0);
    @(negedge iCLOCK);
    iRESET_n = 1'b1;
    idle_cycle();
    $display("periodic down N=2: %0d terminal pulses, then reset", n_tc);

    // Periodic, N=0: terminal every PRESCALE cycles.
    cyc = 0; last_tc = -1; n_tc = 0;
    cycle(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 30; i++) begin
      idle_cycle();
      if (oTC) begin
        if (last_tc >= 0) check_eq("n0_tc_interval", cyc - last_tc, P);
        last_tc = cyc;
        n_tc++;
      end
    end
    check_eq("n0_tc_seen", 32'(n_tc >= 6), 1);
    cycle(0, 1, 0, 0, 0, 0);
    idle_cycle();
    $display("periodic N=0: %0d terminal pulses", n_tc);

    // Load above MAX_COUNT clamps to MAX_COUNT.
    cyc = 0; done_at = -1;
    cycle(1, 0, 0, 250, 1, 0);
    for (int i = 0; i < 900 && done_at < 0; i++) begin
      idle_cycle();
      if (oDONE) begin
        done_at = cyc;
        check_eq("clamp_final_count", 32'(oCOUNT), MAXC);
      end
    end
    check_eq("clamp_done_cycle", done_at, (MAXC + 1) * P + 1);
    idle_cycle();
    $display("load 250 clamped: done at cycle %0d", done_at);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int ld;
      ld = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, 5));
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 5) == 0, ld, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end
    $display("random traffic: 3000 cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
